// File: rtl/uart_fifo.sv
// UART with DEPTH-entry RX and TX FIFOs, programmable 5-8 data bits, parity and stop bits.
// RX and TX share one oversampling baud enable; FSM states are exposed on debug outputs.
module uart_fifo #(
  parameter int DEPTH      = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     baudclk,
  input  logic                     rri,
  output logic                     tro,
  input  logic [1:0]               cls,
  input  logic                     pi,
  input  logic                     epe,
  input  logic                     sbs,
  output logic                     dr,
  input  logic                     drr,
  output logic [7:0]               rbr,
  output logic                     pe,
  output logic                     fe,
  output logic                     oe,
  output logic [$clog2(DEPTH):0]   rxcount,
  output logic [$clog2(DEPTH):0]   txcount,
  input  logic                     tbrl,
  input  logic [7:0]               tbr,
  output logic                     tbre,
  output logic                     tre,
  output logic [2:0]               rx_state_o,
  output logic [2:0]               tx_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_RESYNC
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // Valid/ready: drr pops only when dr=1; tbrl pushes only when tbre=1.
  // Both are one-clock strobes; a strobe without its ready is dropped.

  rx_state_t       rx_state_q, rx_state_d;
  logic [TW-1:0]   rx_tick_q, rx_tick_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_par_q, rx_par_d;
  logic [1:0]      rx_cls_q, rx_cls_d;
  logic            rx_pi_q, rx_pi_d;
  logic            rx_epe_q, rx_epe_d;
  logic            rx_push, rx_fe_new, rx_pe_new;

  tx_state_t       tx_state_q, tx_state_d;
  logic [TW-1:0]   tx_tick_q, tx_tick_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic            tx_par_q, tx_par_d;
  logic [1:0]      tx_cls_q, tx_cls_d;
  logic            tx_pi_q, tx_pi_d;
  logic            tx_sbs_q, tx_sbs_d;
  logic            tro_q, tro_d;
  logic            tx_pop;
  logic [7:0]      tx_data_m;

  logic [9:0]      rx_mem [DEPTH];
  logic [AW-1:0]   rx_wp_q, rx_rp_q;
  logic [CW-1:0]   rx_count_q;
  logic            oe_q, oe_d;
  logic            rx_pop, rx_full, rx_wr;

  logic [7:0]      tx_mem [DEPTH];
  logic [AW-1:0]   tx_wp_q, tx_rp_q;
  logic [CW-1:0]   tx_count_q;
  logic            tx_push;

  // Receiver
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_cls_d   = rx_cls_q;
    rx_pi_d    = rx_pi_q;
    rx_epe_d   = rx_epe_q;
    rx_push    = 1'b0;
    rx_fe_new  = 1'b0;
    rx_pe_new  = rx_pi_q ? 1'b0 : (rx_par_q != !rx_epe_q);
    case (rx_state_q)
      RX_IDLE: begin
        if (!rri) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_data_d  = '0;
          rx_par_d   = 1'b0;
          rx_cls_d   = cls;
          rx_pi_d    = pi;
          rx_epe_d   = epe;
        end
      end
      RX_START: begin
        if (baudclk) begin
          if (rx_tick_q == TICK_MID) begin
            rx_tick_d  = '0;
            rx_state_d = rri ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_d = rx_tick_q + TW'(1);
          end
        end
      end
      RX_DATA: begin
        if (baudclk) begin
          if (rx_tick_q == TICK_LAST) begin
            rx_tick_d           = '0;
            rx_data_d[rx_bit_q] = rri;
            rx_par_d            = rx_par_q ^ rri;
            if (rx_bit_q == (3'd4 + {1'b0, rx_cls_q})) begin
              rx_bit_d   = '0;
              rx_state_d = rx_pi_q ? RX_STOP : RX_PARITY;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end else begin
            rx_tick_d = rx_tick_q + TW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (baudclk) begin
          if (rx_tick_q == TICK_LAST) begin
            rx_tick_d  = '0;
            rx_par_d   = rx_par_q ^ rri;
            rx_state_d = RX_STOP;
          end else begin
            rx_tick_d = rx_tick_q + TW'(1);
          end
        end
      end
      RX_STOP: begin
        if (baudclk) begin
          if (rx_tick_q == TICK_LAST) begin
            rx_tick_d  = '0;
            rx_push    = 1'b1;
            rx_fe_new  = !rri;
            rx_state_d = rri ? RX_IDLE : RX_RESYNC;
          end else begin
            rx_tick_d = rx_tick_q + TW'(1);
          end
        end
      end
      RX_RESYNC: begin
        if (rri) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Transmitter; tro_d is chosen on each transition so tro stays registered.
  assign tx_data_m = tx_mem[tx_rp_q] & (8'hFF >> (2'd3 - cls));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_cls_d   = tx_cls_q;
    tx_pi_d    = tx_pi_q;
    tx_sbs_d   = tx_sbs_q;
    tro_d      = tro_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tro_d = 1'b1;
        if (tx_count_q != '0) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_data_m;
          tx_par_d   = (^tx_data_m) ^ !epe;
          tx_cls_d   = cls;
          tx_pi_d    = pi;
          tx_sbs_d   = sbs;
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_START;
          tro_d      = 1'b0;
        end
      end
      TX_START: begin
        if (baudclk) begin
          if (tx_tick_q == TICK_LAST) begin
            tx_tick_d  = '0;
            tx_state_d = TX_DATA;
            tro_d      = tx_sh_q[0];
          end else begin
            tx_tick_d = tx_tick_q + TW'(1);
          end
        end
      end
      TX_DATA: begin
        if (baudclk) begin
          if (tx_tick_q == TICK_LAST) begin
            tx_tick_d = '0;
            if (tx_bit_q == (3'd4 + {1'b0, tx_cls_q})) begin
              tx_bit_d   = '0;
              tx_state_d = tx_pi_q ? TX_STOP : TX_PARITY;
              tro_d      = tx_pi_q ? 1'b1 : tx_par_q;
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              tx_sh_d  = {1'b0, tx_sh_q[7:1]};
              tro_d    = tx_sh_q[1];
            end
          end else begin
            tx_tick_d = tx_tick_q + TW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (baudclk) begin
          if (tx_tick_q == TICK_LAST) begin
            tx_tick_d  = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_STOP;
            tro_d      = 1'b1;
          end else begin
            tx_tick_d = tx_tick_q + TW'(1);
          end
        end
      end
      TX_STOP: begin
        tro_d = 1'b1;
        if (baudclk) begin
          if (tx_tick_q == TICK_LAST) begin
            tx_tick_d = '0;
            if (tx_bit_q == {2'b00, tx_sbs_q}) tx_state_d = TX_IDLE;
            else tx_bit_d = tx_bit_q + 3'd1;
          end else begin
            tx_tick_d = tx_tick_q + TW'(1);
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // A full RX FIFO still accepts an entry when the head pops in the same clock.
  assign rx_pop  = drr && (rx_count_q != '0);
  assign rx_full = (rx_count_q == FULL);
  assign rx_wr   = rx_push && (!rx_full || rx_pop);
  assign tx_push = tbrl && (tx_count_q != FULL);

  always_comb begin
    oe_d = oe_q;
    if (rx_pop && !(rx_push && rx_full)) oe_d = 1'b0;
    if (rx_push && rx_full && !rx_pop)   oe_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rx_wr)   rx_mem[rx_wp_q] <= {rx_data_d, rx_pe_new, rx_fe_new};
    if (tx_push) tx_mem[tx_wp_q] <= tbr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_cls_q   <= '0;
      rx_pi_q    <= 1'b0;
      rx_epe_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_cls_q   <= '0;
      tx_pi_q    <= 1'b0;
      tx_sbs_q   <= 1'b0;
      tro_q      <= 1'b1;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_count_q <= '0;
      oe_q       <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_count_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
      rx_cls_q   <= rx_cls_d;
      rx_pi_q    <= rx_pi_d;
      rx_epe_q   <= rx_epe_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_cls_q   <= tx_cls_d;
      tx_pi_q    <= tx_pi_d;
      tx_sbs_q   <= tx_sbs_d;
      tro_q      <= tro_d;
      oe_q       <= oe_d;
      if (rx_wr)   rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      rx_count_q <= rx_count_q + CW'(rx_wr) - CW'(rx_pop);
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      tx_count_q <= tx_count_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  assign tro        = tro_q;
  assign dr         = (rx_count_q != '0);
  assign {rbr, pe, fe} = dr ? rx_mem[rx_rp_q] : 10'd0;
  assign oe         = oe_q;
  assign rxcount    = rx_count_q;
  assign txcount    = tx_count_q;
  assign tbre       = (tx_count_q != FULL);
  assign tre        = (tx_state_q == TX_IDLE) && (tx_count_q == '0);
  assign rx_state_o = rx_state_q;
  assign tx_state_o = tx_state_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: directed frames, TX line monitor and RX drain monitor
// checking against expected queues, plus directed flag/count checks.
module tb_uart_fifo;
  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       baudclk = 1'b0;
  logic       rri, drr, tro;
  logic       rri_drv = 1'b1;
  logic       loopback = 1'b0;
  logic [1:0] cls = 2'b11;
  logic       pi = 1'b1, epe = 1'b0, sbs = 1'b0;
  logic       dr, pe, fe, oe, tbre, tre;
  logic       drr_auto = 1'b0, drr_man = 1'b0;
  logic [7:0] rbr;
  logic [7:0] tbr = 8'h00;
  logic       tbrl = 1'b0;
  logic [2:0] rxcount, txcount, rx_state, tx_state;
  logic       clk_run = 1'b1, baud_en = 1'b1, baud_div = 1'b0, auto_drain = 1'b0;

  int errors = 0;
  int checks = 0;
  int reset_epoch = 0;
  logic [19:0] tx_exp_q[$];   // {frame length, frame bits LSB first}
  logic [9:0]  rx_exp_q[$];   // {data, pe, fe}

  assign rri = loopback ? tro : rri_drv;
  assign drr = drr_auto | drr_man;

  uart_fifo #(.DEPTH(4), .OVERSAMPLE(16)) dut (
    .clock(clock), .reset_n(reset_n), .baudclk(baudclk), .rri(rri), .tro(tro),
    .cls(cls), .pi(pi), .epe(epe), .sbs(sbs), .dr(dr), .drr(drr), .rbr(rbr),
    .pe(pe), .fe(fe), .oe(oe), .rxcount(rxcount), .txcount(txcount),
    .tbrl(tbrl), .tbr(tbr), .tbre(tbre), .tre(tre),
    .rx_state_o(rx_state), .tx_state_o(tx_state)
  );

  // Clock and baud enable (one tick every second clock)
  always #5 if (clk_run) clock = ~clock;

  initial forever begin
    @(negedge clock);
    baud_div = ~baud_div;
    baudclk  = baud_en & baud_div;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clock);
      if (baudclk) c++;
    end
  endtask

  task automatic load(input logic [7:0] b);
    @(negedge clock);
    tbr  = b;
    tbrl = 1'b1;
    @(negedge clock);
    tbrl = 1'b0;
  endtask

  task automatic load_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      tbr  = first + 8'(i);
      tbrl = 1'b1;
    end
    @(negedge clock);
    tbrl = 1'b0;
  endtask

  task automatic send_serial(input logic [15:0] frame, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      rri_drv = frame[i];
      wait_ticks(16);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while (c < budget && !(tre && rx_state == 3'd0 && tx_exp_q.size() == 0 &&
                           (!auto_drain || rx_exp_q.size() == 0))) begin
      @(negedge clock);
      c++;
    end
    check({name, " done"}, 32'(c < budget), 32'd1);
    repeat (4) @(negedge clock);
  endtask

  task automatic mon_wait(input int k, input int ep, inout bit ab);
    int c = 0;
    while (c < k && !ab) begin
      @(posedge clock);
      if (reset_epoch != ep) ab = 1'b1;
      else if (baudclk) c++;
    end
    if (!ab) @(negedge clock);
  endtask

  // TX monitor: samples tro at mid-bit and compares a whole frame
  initial forever begin
    int ep, n;
    bit ab;
    logic [15:0] got;
    logic [19:0] e;
    @(negedge clock);
    if (reset_n && tro === 1'b0) begin
      ep  = reset_epoch;
      ab  = 1'b0;
      got = '0;
      n   = (tx_exp_q.size() != 0) ? int'(tx_exp_q[0][19:16]) : 10;
      mon_wait(8, ep, ab);
      got[0] = tro;
      for (int i = 1; i < n; i++) begin
        mon_wait(16, ep, ab);
        if (!ab) got[i] = tro;
      end
      if (!ab) begin
        if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx frame: got unexpected %0h expected none", got);
        end else begin
          e = tx_exp_q.pop_front();
          check("tx frame", {12'd0, 4'(n), got}, {12'd0, e});
        end
      end
    end
  end

  // RX monitor: drains and compares every entry presented with dr
  initial forever begin
    @(negedge clock);
    drr_auto = 1'b0;
    if (auto_drain && reset_n && dr) begin
      if (rx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx entry: got unexpected %0h expected none", {rbr, pe, fe});
      end else begin
        check("rx entry", {22'd0, rbr, pe, fe}, {22'd0, rx_exp_q.pop_front()});
      end
      drr_auto = 1'b1;
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("reset flags", {25'd0, tro, dr, pe, fe, oe, tbre, tre}, 32'b1000011);
    check("reset rbr", {24'd0, rbr}, 32'h0);
    check("reset counts", {26'd0, rxcount, txcount}, 32'h0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 8N1 loopback of A5
    loopback = 1'b1;
    auto_drain = 1'b1;
    tx_exp_q.push_back({4'd10, 16'h034A});
    rx_exp_q.push_back({8'hA5, 2'b00});
    load(8'hA5);
    wait_done(3000, "a5");
    check("a5 tre", {31'd0, tre}, 32'd1);

    // 7E2 loopback of 41, then forced bad parity
    cls = 2'b10; pi = 1'b0; epe = 1'b1; sbs = 1'b1;
    tx_exp_q.push_back({4'd11, 16'h0682});
    rx_exp_q.push_back({8'h41, 2'b00});
    load(8'h41);
    wait_done(3000, "7e2");
    loopback = 1'b0;
    rx_exp_q.push_back({8'h41, 2'b10});
    send_serial(16'h0782, 11);
    wait_done(3000, "bad parity");

    // Framing error and resync
    cls = 2'b11; pi = 1'b1; epe = 1'b0; sbs = 1'b0;
    rx_exp_q.push_back({8'h3C, 2'b01});
    send_serial(16'h0078, 10);
    check("resync state", {29'd0, rx_state}, 32'd5);
    wait_ticks(4);
    check("resync hold", {29'd0, rx_state}, 32'd5);
    rri_drv = 1'b1;
    repeat (3) @(negedge clock);
    check("resync exit", {29'd0, rx_state}, 32'd0);
    check("fe drained", {29'd0, rxcount}, 32'd0);

    // False start
    @(negedge clock);
    rri_drv = 1'b0;
    repeat (2) @(negedge clock);
    check("false start entry", {29'd0, rx_state}, 32'd1);
    wait_ticks(4);
    @(negedge clock);
    rri_drv = 1'b1;
    wait_ticks(10);
    @(negedge clock);
    check("false start idle", {29'd0, rx_state}, 32'd0);
    check("false start count", {29'd0, rxcount}, 32'd0);

    // Overrun: five characters, no drain
    loopback = 1'b1;
    auto_drain = 1'b0;
    for (int i = 1; i <= 5; i++) tx_exp_q.push_back({4'd10, 16'h0200 | 16'(i << 1)});
    load_burst(8'h01, 5);
    wait_done(5000, "overrun");
    check("overrun count", {29'd0, rxcount}, 32'd4);
    check("overrun oe", {31'd0, oe}, 32'd1);
    check("overrun head", {22'd0, rbr, pe, fe}, {22'd0, 8'h01, 2'b00});
    @(negedge clock);
    drr_man = 1'b1;
    @(negedge clock);
    drr_man = 1'b0;
    check("pop head", {24'd0, rbr}, 32'h02);
    check("pop oe", {31'd0, oe}, 32'd0);
    check("pop count", {29'd0, rxcount}, 32'd3);
    for (int i = 2; i <= 4; i++) rx_exp_q.push_back({8'(i), 2'b00});
    auto_drain = 1'b1;
    wait_done(500, "drain");
    check("drain count", {29'd0, rxcount}, 32'd0);

    // TX FIFO fill with baud held off
    baud_en = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= 5; i++) begin
      tx_exp_q.push_back({4'd10, 16'h0220 | 16'(i << 1)});
      rx_exp_q.push_back({8'h10 + 8'(i), 2'b00});
    end
    load_burst(8'h11, 5);
    check("tx full count", {29'd0, txcount}, 32'd4);
    check("tx full flags", {30'd0, tbre, tre}, 32'd0);
    load(8'h16);
    check("tx 6th ignored", {29'd0, txcount}, 32'd4);
    baud_en = 1'b1;
    wait_done(5000, "tx fifo");
    check("tx empty", {28'd0, txcount, tre}, 32'd1);

    // Reset mid-character with the clock stopped
    load(8'h5A);
    wait_ticks(64);
    @(negedge clock);
    clk_run = 1'b0;
    #20;
    reset_epoch++;
    tx_exp_q.delete();
    rx_exp_q.delete();
    reset_n = 1'b0;
    #1;
    check("async reset tro", {31'd0, tro}, 32'd1);
    check("async reset counts", {26'd0, rxcount, txcount}, 32'd0);
    check("async reset states", {26'd0, rx_state, tx_state}, 32'd0);
    check("async reset flags", {28'd0, dr, oe, tbre, tre}, 32'b0011);
    #10 reset_n = 1'b1;
    #10 clk_run = 1'b1;
    repeat (3) @(negedge clock);
    tx_exp_q.push_back({4'd10, 16'h02B4});
    rx_exp_q.push_back({8'h5A, 2'b00});
    load(8'h5A);
    wait_done(3000, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
